// File: rtl/clight_multi_ctrl.sv
// Multi-way staircase light controller: N_SW synchronised, debounced switches each toggle
// one shared light, with an optional auto-off timer.
module clight_multi_ctrl #(
  parameter int unsigned N_SW      = 3,
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter bit          LIGHT_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw,
  input  logic            timer_en,
  output logic            light,
  output logic            toggle,
  output logic            expired,
  output logic [N_SW-1:0] sw_db
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] DbLast  = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [TW-1:0] TmrLoad = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TW-1:0] TmrOne  = TW'(1);

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q [N_SW];
  logic [CW-1:0]   cnt_d [N_SW];
  logic [N_SW-1:0] sw_db_d;
  logic [N_SW-1:0] chg;
  logic            flip;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            light_d, toggle_d, expired_d;

  // A bit is accepted only after DEBOUNCE consecutive mismatching samples.
  always_comb begin
    sw_db_d = sw_db;
    chg     = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != sw_db[i]) begin
        if (cnt_q[i] == DbLast) begin
          sw_db_d[i] = sync2_q[i];
          chg[i]     = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CntOne;
        end
      end
    end
  end

  assign flip = ^chg;

  // A flip always wins over expiry; the timer only reloads on a turn-on.
  always_comb begin
    light_d   = light;
    tmr_d     = tmr_q;
    toggle_d  = 1'b0;
    expired_d = 1'b0;
    if (flip) begin
      light_d  = ~light;
      toggle_d = 1'b1;
      if (!light) begin
        tmr_d = TmrLoad;
      end
    end else if ((TIMEOUT > 0) && light && timer_en) begin
      if (tmr_q == '0) begin
        light_d   = 1'b0;
        expired_d = 1'b1;
      end else begin
        tmr_d = tmr_q - TmrOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_db   <= '0;
      for (int i = 0; i < int'(N_SW); i++) begin
        cnt_q[i] <= '0;
      end
      tmr_q   <= TmrLoad;
      light   <= LIGHT_RST;
      toggle  <= 1'b0;
      expired <= 1'b0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      sw_db   <= sw_db_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      light   <= light_d;
      toggle  <= toggle_d;
      expired <= expired_d;
    end
  end

endmodule

// File: tb/tb_clight_multi_ctrl.sv
// Self-checking bench for clight_multi_ctrl: directed scenarios plus a randomized run
// checked against a sample-window reference model.
module tb_clight_multi_ctrl;

  localparam int N  = 3;
  localparam int DB = 4;
  localparam int TO = 16;
  localparam bit LR = 1'b1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] sw = '0;
  logic         timer_en = 1'b0;
  logic         light, toggle, expired;
  logic [N-1:0] sw_db;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clight_multi_ctrl #(
    .N_SW     (N),
    .DEBOUNCE (DB),
    .TIMEOUT  (TO),
    .LIGHT_RST(LR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .timer_en(timer_en),
    .light   (light),
    .toggle  (toggle),
    .expired (expired),
    .sw_db   (sw_db)
  );

  // Reference model: hist[j] is the raw switch vector applied j edges ago. A bit is
  // accepted when the last DB synchronised samples (hist[2..DB+1]) all differ from it.
  logic [N-1:0] hist [DB+2];
  logic [N-1:0] m_db;
  logic         m_light, m_toggle, m_expired;
  int           m_elapsed;

  task automatic model_reset();
    for (int j = 0; j < DB + 2; j++) hist[j] = '0;
    m_db      = '0;
    m_light   = LR;
    m_toggle  = 1'b0;
    m_expired = 1'b0;
    m_elapsed = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] new_db;
    logic         flip;
    bit           all_diff;
    for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = sw;
    new_db = m_db;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
      if (all_diff) new_db[i] = ~m_db[i];
    end
    flip      = ^(new_db ^ m_db);
    m_toggle  = 1'b0;
    m_expired = 1'b0;
    if (flip) begin
      m_toggle = 1'b1;
      if (!m_light) m_elapsed = 0;
      m_light = ~m_light;
    end else if (TO > 0 && m_light && timer_en) begin
      if (m_elapsed == TO - 1) begin
        m_light   = 1'b0;
        m_expired = 1'b1;
      end else begin
        m_elapsed++;
      end
    end
    m_db = new_db;
  endtask

  // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
  task automatic step(input logic [N-1:0] s, input logic en);
    sw       = s;
    timer_en = en;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    sw       = '0;
    timer_en = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #12;
    exp = {1'b1, 1'b0, 1'b0, 3'b000};
    checks++;
    if ({light, toggle, expired, sw_db} !== exp) begin
      errors++;
      $display("FAIL reset: got %b expected %b (light,toggle,expired,sw_db)",
               {light, toggle, expired, sw_db}, exp);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_toggle();
    logic [5:0] exp;
    for (int n = 0; n < 8; n++) begin
      step(3'b001, 1'b0);
      exp = {(n < 5), (n == 5), 1'b0, (n < 5) ? 3'b000 : 3'b001};
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL single_toggle_on n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
    for (int n = 0; n < 8; n++) begin
      step(3'b011, 1'b0);
      exp = {(n >= 5), (n == 5), 1'b0, (n < 5) ? 3'b001 : 3'b011};
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL single_toggle_second n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] exp;
    exp = {1'b1, 1'b0, 1'b0, 3'b000};
    for (int n = 0; n < 10; n++) step(3'b000, 1'b0);
    for (int n = 0; n < 11; n++) begin
      step((n < 3) ? 3'b001 : 3'b000, 1'b0);
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL bounce n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
  endtask

  task automatic test_even_change();
    logic [5:0] exp;
    for (int n = 0; n < 8; n++) begin
      step(3'b011, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, (n < 5) ? 3'b000 : 3'b011};
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL even_change n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    logic [N-1:0] from_v, to_v;
    for (int n = 0; n < 8; n++) step(3'b111, 1'b0);
    exp = {1'b0, 1'b0, 1'b0, 3'b111};
    checks++;
    if ({light, toggle, expired, sw_db} !== exp) begin
      errors++;
      $display("FAIL timeout_prep: got %b expected %b", {light, toggle, expired, sw_db}, exp);
    end
    for (int r = 0; r < 2; r++) begin
      from_v = (r == 0) ? 3'b111 : 3'b011;
      to_v   = (r == 0) ? 3'b011 : 3'b111;
      for (int n = 0; n < 23; n++) begin
        step(to_v, 1'b1);
        exp = {(n >= 5 && n <= 20), (n == 5), (n == 21), (n < 5) ? from_v : to_v};
        checks++;
        if ({light, toggle, expired, sw_db} !== exp) begin
          errors++;
          $display("FAIL timeout r=%0d n=%0d: got %b expected %b", r, n,
                   {light, toggle, expired, sw_db}, exp);
        end
      end
    end
  endtask

  task automatic test_timer_hold();
    logic [5:0] exp;
    for (int n = 0; n < 6; n++) step(3'b011, 1'b1);
    exp = {1'b1, 1'b1, 1'b0, 3'b011};
    checks++;
    if ({light, toggle, expired, sw_db} !== exp) begin
      errors++;
      $display("FAIL hold_turn_on: got %b expected %b", {light, toggle, expired, sw_db}, exp);
    end
    for (int n = 0; n < 8; n++) step(3'b011, 1'b1);
    exp = {1'b1, 1'b0, 1'b0, 3'b011};
    for (int n = 0; n < 20; n++) begin
      step(3'b011, 1'b0);
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL hold_disabled n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
    for (int m = 1; m <= 9; m++) begin
      step(3'b011, 1'b1);
      exp = {(m < 8), 1'b0, (m == 8), 3'b011};
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL hold_resume m=%0d: got %b expected %b", m,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    for (int n = 0; n < 10; n++) step(3'b111, 1'b1);
    for (int n = 0; n < 4; n++) step(3'b110, 1'b1);
    // Assert reset mid-cycle, well away from any clock edge.
    #3 rst_n = 1'b0;
    sw       = 3'b001;
    timer_en = 1'b1;
    model_reset();
    #1;
    exp = {1'b1, 1'b0, 1'b0, 3'b000};
    checks++;
    if ({light, toggle, expired, sw_db} !== exp) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b", {light, toggle, expired, sw_db}, exp);
    end
    #2 rst_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step(3'b001, 1'b1);
      exp = {(n < 6), (n == 6), 1'b0, (n < 6) ? 3'b000 : 3'b001};
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL post_reset_debounce n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
    #3 rst_n = 1'b0;
    sw = 3'b000;
    model_reset();
    #3 rst_n = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step(3'b000, 1'b1);
      exp = {(n < 16), 1'b0, (n == 16), 3'b000};
      checks++;
      if ({light, toggle, expired, sw_db} !== exp) begin
        errors++;
        $display("FAIL reset_window n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] s;
    logic         en;
    s = sw;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) s = N'($urandom);
      en = ($urandom_range(0, 7) != 0);
      step(s, en);
      checks++;
      if ({light, toggle, expired, sw_db} !== {m_light, m_toggle, m_expired, m_db}) begin
        errors++;
        $display("FAIL random n=%0d: got %b expected %b", n,
                 {light, toggle, expired, sw_db}, {m_light, m_toggle, m_expired, m_db});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_toggle();
    test_bounce();
    test_even_change();
    test_timeout();
    test_timer_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
